// File: rtl/stream_mux_reg.sv
// NUM_IN:1 stream selector with a one-entry registered output buffer.
// Invalid select codes never transfer data and raise sel_err one cycle later.
module stream_mux_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 7,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        select,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        xfer_cnt
);

  localparam logic [SEL_W:0] NUM_IN_CODE = (SEL_W+1)'(NUM_IN);

  logic                 sel_ok_s;
  logic                 space_s;
  logic                 load_s;
  logic                 drain_s;
  logic [NUM_IN-1:0]    in_ready_s;
  logic [WIDTH-1:0]     sel_data_s;
  logic [WIDTH-1:0]     out_data_r;
  logic                 out_valid_r;
  logic                 sel_err_r;
  logic [CNT_W-1:0]     xfer_cnt_r;

  // Channel decode and AND-OR data mux; an out-of-range code matches no channel.
  always_comb begin
    sel_ok_s   = ({1'b0, select} < NUM_IN_CODE);
    space_s    = ~out_valid_r | out_ready;
    in_ready_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready_s[i] = RESET_N & sel_ok_s & (select == SEL_W'(i)) & space_s;
      sel_data_s    = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{select == SEL_W'(i)}});
    end
    load_s  = |(in_valid & in_ready_s);
    drain_s = out_valid_r & out_ready;
  end

  // Output buffer, select-error flag and handshake counter.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      sel_err_r   <= 1'b0;
      xfer_cnt_r  <= '0;
    end else begin
      if (load_s) begin
        out_data_r  <= sel_data_s;
        out_valid_r <= 1'b1;
      end else if (drain_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      sel_err_r <= ~sel_ok_s;
      if (drain_s) begin
        xfer_cnt_r <= xfer_cnt_r + CNT_W'(1);
      end else begin
        xfer_cnt_r <= xfer_cnt_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign sel_err   = sel_err_r;
  assign xfer_cnt  = xfer_cnt_r;

endmodule

// File: tb/tb_stream_mux_reg.sv
// Directed bench for stream_mux_reg: a 7x32 instance and a 2x8 instance, both with a 4-bit counter.
module tb_stream_mux_reg;

  logic        CLK;
  logic        rst_n;

  logic [7*32-1:0] in_data0;
  logic [6:0]      in_valid0;
  logic [6:0]      in_ready0;
  logic [2:0]      select0;
  logic [31:0]     out_data0;
  logic            out_valid0;
  logic            out_ready0;
  logic            sel_err0;
  logic [3:0]      xfer_cnt0;

  logic [15:0]     in_data1;
  logic [1:0]      in_valid1;
  logic [1:0]      in_ready1;
  logic [0:0]      select1;
  logic [7:0]      out_data1;
  logic            out_valid1;
  logic            out_ready1;
  logic            sel_err1;
  logic [3:0]      xfer_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  stream_mux_reg #(.WIDTH(32), .NUM_IN(7), .SEL_W(3), .CNT_W(4)) u_dut0 (
    .CLK(CLK), .RESET_N(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .select(select0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .sel_err(sel_err0),
    .xfer_cnt(xfer_cnt0)
  );

  stream_mux_reg #(.WIDTH(8), .NUM_IN(2), .SEL_W(1), .CNT_W(4)) u_dut1 (
    .CLK(CLK), .RESET_N(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .select(select1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sel_err(sel_err1),
    .xfer_cnt(xfer_cnt1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ch0(input int ch, input logic [31:0] v);
    in_data0[ch*32 +: 32] = v;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Test 1: reset with every channel offering data
    rst_n      = 1'b0;
    in_data0   = '0;
    for (int c = 0; c < 7; c++) set_ch0(c, 32'hC000_0000 + 32'(c));
    in_valid0  = 7'h7F;
    select0    = 3'd0;
    out_ready0 = 1'b1;
    in_data1   = 16'h0000;
    in_valid1  = 2'b00;
    select1    = 1'b0;
    out_ready1 = 1'b1;
    #1;
    check_eq("rst_in_ready_comb", 64'(in_ready0), 64'd0);
    tick();
    tick();
    check_eq("rst_out_valid", 64'(out_valid0), 64'd0);
    check_eq("rst_out_data", 64'(out_data0), 64'd0);
    check_eq("rst_xfer_cnt", 64'(xfer_cnt0), 64'd0);
    check_eq("rst_sel_err", 64'(sel_err0), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready0), 64'd0);
    check_eq("rst_out_valid1", 64'(out_valid1), 64'd0);

    // Test 2: stream 0xA0..0xA3 from channel 2, other channels also valid
    rst_n   = 1'b1;
    select0 = 3'd2;
    for (int i = 0; i < 4; i++) begin
      set_ch0(2, 32'hA0 + 32'(i));
      #1;
      check_eq("stream_in_ready", 64'(in_ready0), 64'h04);
      tick();
      check_eq("stream_out_data", 64'(out_data0), 64'hA0 + 64'(i));
      check_eq("stream_out_valid", 64'(out_valid0), 64'd1);
    end
    in_valid0 = 7'h00;
    tick();
    check_eq("stream_drained", 64'(out_valid0), 64'd0);
    check_eq("stream_xfer_cnt", 64'(xfer_cnt0), 64'd4);
    check_eq("stream_data_hold", 64'(out_data0), 64'hA3);

    // Test 3: backpressure holding 0x55 while select moves 1 -> 4
    in_valid0  = 7'h7F;
    out_ready0 = 1'b0;
    select0    = 3'd1;
    set_ch0(1, 32'h55);
    set_ch0(4, 32'h44);
    #1;
    check_eq("bp_load_in_ready", 64'(in_ready0), 64'h02);
    tick();
    check_eq("bp_loaded", 64'(out_data0), 64'h55);
    for (int k = 0; k < 3; k++) begin
      select0 = (k == 0) ? 3'd1 : 3'd4;
      #1;
      check_eq("bp_in_ready", 64'(in_ready0), 64'd0);
      tick();
      check_eq("bp_data_hold", 64'(out_data0), 64'h55);
      check_eq("bp_valid_hold", 64'(out_valid0), 64'd1);
    end
    out_ready0 = 1'b1;
    #1;
    check_eq("bp_release_in_ready", 64'(in_ready0), 64'h10);
    tick();
    check_eq("bp_next_word", 64'(out_data0), 64'h44);
    check_eq("bp_next_valid", 64'(out_valid0), 64'd1);
    check_eq("bp_xfer_cnt", 64'(xfer_cnt0), 64'd5);
    in_valid0 = 7'h00;
    tick();
    check_eq("bp_drain_cnt", 64'(xfer_cnt0), 64'd6);

    // Test 4: invalid select code 7 with a word already buffered
    in_valid0  = 7'h7F;
    out_ready0 = 1'b0;
    select0    = 3'd3;
    set_ch0(3, 32'h33);
    tick();
    check_eq("inv_pre_load", 64'(out_data0), 64'h33);
    check_eq("inv_pre_sel_err", 64'(sel_err0), 64'd0);
    select0    = 3'd7;
    out_ready0 = 1'b1;
    #1;
    check_eq("inv_in_ready", 64'(in_ready0), 64'd0);
    tick();
    check_eq("inv_sel_err", 64'(sel_err0), 64'd1);
    check_eq("inv_drained", 64'(out_valid0), 64'd0);
    check_eq("inv_xfer_cnt", 64'(xfer_cnt0), 64'd7);
    check_eq("inv_data_hold", 64'(out_data0), 64'h33);
    tick();
    check_eq("inv_no_load", 64'(out_valid0), 64'd0);
    check_eq("inv_cnt_steady", 64'(xfer_cnt0), 64'd7);
    select0   = 3'd0;
    in_valid0 = 7'h00;
    tick();
    check_eq("inv_sel_err_clear", 64'(sel_err0), 64'd0);

    // Test 5: reset while 0x1234 is pending and the consumer is ready
    in_valid0  = 7'h01;
    out_ready0 = 1'b0;
    set_ch0(0, 32'h1234);
    tick();
    check_eq("mid_loaded", 64'(out_data0), 64'h1234);
    in_valid0  = 7'h00;
    out_ready0 = 1'b1;
    rst_n      = 1'b0;
    #1;
    check_eq("mid_in_ready", 64'(in_ready0), 64'd0);
    tick();
    check_eq("mid_out_valid", 64'(out_valid0), 64'd0);
    check_eq("mid_out_data", 64'(out_data0), 64'd0);
    check_eq("mid_xfer_cnt", 64'(xfer_cnt0), 64'd0);
    rst_n = 1'b1;

    // Test 6a: 17 handshakes wrap a 4-bit counter to 1
    in_valid0 = 7'h7F;
    select0   = 3'd5;
    for (int i = 0; i < 17; i++) begin
      set_ch0(5, 32'(i));
      tick();
    end
    in_valid0 = 7'h00;
    tick();
    check_eq("wrap_last_data", 64'(out_data0), 64'd16);
    check_eq("wrap_xfer_cnt", 64'(xfer_cnt0), 64'd1);

    // Test 6b: same on the 2x8 instance, then one word from channel 0
    in_valid1 = 2'b11;
    select1   = 1'b1;
    in_data1[7:0] = 8'hEE;
    for (int i = 0; i < 17; i++) begin
      in_data1[15:8] = 8'(i + 8'h30);
      #1;
      check_eq("p1_in_ready", 64'(in_ready1), 64'h2);
      tick();
      check_eq("p1_out_data", 64'(out_data1), 64'(i + 8'h30));
    end
    select1 = 1'b0;
    #1;
    check_eq("p1_ch0_in_ready", 64'(in_ready1), 64'h1);
    tick();
    check_eq("p1_ch0_data", 64'(out_data1), 64'hEE);
    in_valid1 = 2'b00;
    tick();
    check_eq("p1_xfer_cnt", 64'(xfer_cnt1), 64'd2);
    check_eq("p1_sel_err", 64'(sel_err1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
